fc_bias_add: RTL

FC_BIAS_ADD -- requirements
Module: fc_bias_add

---
 rtl/fc_bias_add_pkg.sv | 17 +
 rtl/fc_bias_add_if.sv | 28 ++
 rtl/fc_sat_add.sv | 17 +
 rtl/fc_bias_add.sv | 115 +++++++++++
 4 files changed

// File: rtl/fc_bias_add_pkg.sv
// Shared constants and types for the FC bias-add stage.
package fc_bias_add_pkg;

  localparam int DDR_AXIS_DATA_WIDTH = 64;
  localparam int DEF_LANES           = DDR_AXIS_DATA_WIDTH / 8;
  localparam int LANE_W              = 32;

  localparam logic signed [LANE_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [LANE_W-1:0] SAT_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BIAS = 2'd1,
    RUN       = 2'd2
  } fc_state_e;

endpackage

// File: rtl/fc_bias_add_if.sv
// Accumulator-in / biased-result-out stream pair.
interface fc_bias_add_if
  import fc_bias_add_pkg::*;
#(
  parameter int LANES = DEF_LANES
) ();

  logic                             acc_vld;
  logic                             acc_rdy;
  logic [LANES-1:0][LANE_W-1:0]     acc_data;
  logic                             out_vld;
  logic                             out_rdy;
  logic [LANES-1:0][LANE_W-1:0]     out_data;
  logic                             out_last;

  // Environment side: produces accumulators, consumes results.
  modport master (
    output acc_vld, acc_data, out_rdy,
    input  acc_rdy, out_vld, out_data, out_last
  );

  // Bias-add block side.
  modport slave (
    input  acc_vld, acc_data, out_rdy,
    output acc_rdy, out_vld, out_data, out_last
  );

endinterface

// File: rtl/fc_sat_add.sv
// One-lane signed 32+32 adder clipped to the 32-bit signed range.
module fc_sat_add
  import fc_bias_add_pkg::*;
(
  input  logic signed [LANE_W-1:0] a,
  input  logic signed [LANE_W-1:0] b,
  output logic signed [LANE_W-1:0] y
);

  logic [LANE_W:0] sum;

  assign sum = {a[LANE_W-1], a} + {b[LANE_W-1], b};
  // Overflow iff the two top bits of the 33-bit sum disagree; the true sign picks the rail.
  assign y = (sum[LANE_W] != sum[LANE_W-1]) ? (sum[LANE_W] ? SAT_MIN : SAT_MAX)
                                            : sum[LANE_W-1:0];

endmodule

// File: rtl/fc_bias_add.sv
// Adds a per-vector bias to the accumulator stream with saturation.
// The bias for vector k+1 is requested (read_next) as soon as vector k's
// bias is captured, so a steady accumulator stream only waits on the
// upstream bias latency, never on an extra round trip.
module fc_bias_add
  import fc_bias_add_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int BIAS_LAT = 12,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_pulse,
  input  logic [CNT_W-1:0]             n_vec,
  input  logic [LANES-1:0][LANE_W-1:0] bias,
  output logic                         read_next,
  fc_bias_add_if.slave                 io,
  output logic                         done
);

  localparam int LAT_W = (BIAS_LAT > 1) ? $clog2(BIAS_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(BIAS_LAT - 1);

  fc_state_e                    state;
  logic [CNT_W-1:0]             remaining;
  logic [LAT_W-1:0]             lat_cnt;
  logic                         pf_pend;     // a bias fetch is in flight upstream
  logic [LANES-1:0][LANE_W-1:0] bias_q;
  logic                         bias_q_vld;
  logic [LANES-1:0][LANE_W-1:0] sum_w;
  logic                         acc_hs;
  logic                         out_hs;
  logic                         capture;

  assign io.acc_rdy = bias_q_vld && (!io.out_vld || io.out_rdy);
  assign acc_hs     = io.acc_vld && io.acc_rdy;
  assign out_hs     = io.out_vld && io.out_rdy;
  assign capture    = pf_pend && (lat_cnt == '0) && !bias_q_vld;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fc_sat_add u_add (
      .a (io.acc_data[g]),
      .b (bias_q[g]),
      .y (sum_w[g])
    );
  end

  // Job control, bias prefetch and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      remaining   <= '0;
      lat_cnt     <= '0;
      pf_pend     <= 1'b0;
      bias_q      <= '0;
      bias_q_vld  <= 1'b0;
      read_next   <= 1'b0;
      io.out_vld  <= 1'b0;
      io.out_data <= '0;
      io.out_last <= 1'b0;
      done        <= 1'b0;
    end else begin
      read_next <= 1'b0;
      done      <= 1'b0;
      if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);

      case (state)
        IDLE: begin
          if (start_pulse) begin
            if (n_vec != '0) begin
              remaining <= n_vec;
              lat_cnt   <= LAT_RELOAD;
              pf_pend   <= 1'b1;
              state     <= WAIT_BIAS;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          // bias_q is only empty after its vector was consumed, so remaining
          // here equals the number of bias vectors still to capture.
          if (capture) begin
            bias_q     <= bias;
            bias_q_vld <= 1'b1;
            state      <= RUN;
            if (remaining > CNT_W'(1)) begin
              read_next <= 1'b1;
              lat_cnt   <= LAT_RELOAD;
            end else begin
              pf_pend <= 1'b0;
            end
          end

          if (acc_hs) begin
            io.out_data <= sum_w;
            io.out_vld  <= 1'b1;
            io.out_last <= (remaining == CNT_W'(1));
            remaining   <= remaining - CNT_W'(1);
            bias_q_vld  <= 1'b0;
          end else if (out_hs) begin
            io.out_vld  <= 1'b0;
            io.out_last <= 1'b0;
            if (io.out_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
